// File: rtl/posit_fma_arbiter_if.sv
// Requester, datapath and response signals for posit_fma_arbiter.
// The arbiter connects to the slave modport; requesters and the datapath drive the master side.
interface posit_fma_arbiter_if #(
    parameter int N    = 32,
    parameter int NREQ = 4
);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*N-1:0] req_a;
    logic [NREQ*N-1:0] req_b;
    logic [NREQ*N-1:0] req_c;
    logic              fma_valid;
    logic [N-1:0]      fma_a;
    logic [N-1:0]      fma_b;
    logic [N-1:0]      fma_c;
    logic [N-1:0]      fma_out;
    logic [NREQ-1:0]   rsp_valid;
    logic [NREQ-1:0]   rsp_ready;
    logic [NREQ*N-1:0] rsp_data;
    logic              busy;

    modport slave (
        input  req_valid, req_a, req_b, req_c, fma_out, rsp_ready,
        output req_ready, fma_valid, fma_a, fma_b, fma_c, rsp_valid, rsp_data, busy
    );

    modport master (
        output req_valid, req_a, req_b, req_c, fma_out, rsp_ready,
        input  req_ready, fma_valid, fma_a, fma_b, fma_c, rsp_valid, rsp_data, busy
    );
endinterface

// File: rtl/posit_fma_arbiter.sv
// Round-robin sharing of one fixed-latency posit FMA pipeline among NREQ requesters,
// with a tag pipe tracking ownership and per-requester response holding registers.
module posit_fma_arbiter #(
    parameter int N    = 32,
    parameter int ES   = 2,
    parameter int NREQ = 4,
    parameter int LAT  = 3
) (
    input logic                clk,
    input logic                rst_n,
    posit_fma_arbiter_if.slave bus
);
    localparam int IDW = $clog2(NREQ);

    if (NREQ < 2 || LAT < 1 || ES < 0 || ES > N - 2) begin : g_bad_param
        $error("posit_fma_arbiter: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_INFLIGHT,
        S_HOLD
    } slot_e;

    logic [NREQ-1:0] idle_vec;
    logic [NREQ-1:0] hold_vec;
    logic [NREQ-1:0] eligible;
    logic [NREQ-1:0] grant_oh;
    logic            grant_vld;
    logic [IDW-1:0]  grant_id;
    logic [IDW-1:0]  ptr_q;
    logic [IDW-1:0]  ptr_d;
    logic [LAT-1:0]  tag_vld;
    logic [IDW-1:0]  tag_id [LAT];
    logic            exit_vld;
    logic [IDW-1:0]  exit_id;
    logic [IDW:0]    scan_sum;
    logic [IDW-1:0]  scan_idx;

    // Nothing is eligible while reset is held, so no grant can leak out during reset.
    assign eligible = {NREQ{rst_n}} & bus.req_valid & idle_vec;

    always_comb begin
        grant_vld = 1'b0;
        grant_id  = '0;
        scan_sum  = '0;
        scan_idx  = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan_sum = {1'b0, ptr_q} + (IDW + 1)'(k);
            if (scan_sum >= (IDW + 1)'(NREQ)) begin
                scan_sum = scan_sum - (IDW + 1)'(NREQ);
            end
            scan_idx = scan_sum[IDW-1:0];
            if (!grant_vld && eligible[scan_idx]) begin
                grant_vld = 1'b1;
                grant_id  = scan_idx;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (grant_vld) begin
            ptr_d = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign grant_oh      = grant_vld ? (NREQ'(1) << grant_id) : '0;
    assign bus.req_ready = grant_oh;
    assign bus.fma_valid = grant_vld;
    assign bus.fma_a     = grant_vld ? bus.req_a[grant_id*N +: N] : '0;
    assign bus.fma_b     = grant_vld ? bus.req_b[grant_id*N +: N] : '0;
    assign bus.fma_c     = grant_vld ? bus.req_c[grant_id*N +: N] : '0;

    // Tag pipe: stage LAT-1 lines up with the cycle fma_out carries that issue's result.
    for (genvar gi = 0; gi < LAT; gi++) begin : g_tag
        logic           vld_q;
        logic [IDW-1:0] id_q;
        logic           vld_d;
        logic [IDW-1:0] id_d;

        if (gi == 0) begin : g_head
            assign vld_d = grant_vld;
            assign id_d  = grant_id;
        end else begin : g_body
            assign vld_d = tag_vld[gi-1];
            assign id_d  = tag_id[gi-1];
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                vld_q <= 1'b0;
                id_q  <= '0;
            end else begin
                vld_q <= vld_d;
                id_q  <= id_d;
            end
        end

        assign tag_vld[gi] = vld_q;
        assign tag_id[gi]  = id_q;
    end

    assign exit_vld = tag_vld[LAT-1];
    assign exit_id  = tag_id[LAT-1];

    // One op outstanding per slot, so a tag exit and a response handshake never collide.
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_slot
        slot_e        slot_q;
        logic [N-1:0] data_q;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                slot_q <= S_IDLE;
                data_q <= '0;
            end else begin
                case (slot_q)
                    S_IDLE: begin
                        if (grant_oh[gi]) begin
                            slot_q <= S_INFLIGHT;
                        end
                    end
                    S_INFLIGHT: begin
                        if (exit_vld && (exit_id == IDW'(gi))) begin
                            slot_q <= S_HOLD;
                            data_q <= bus.fma_out;
                        end
                    end
                    S_HOLD: begin
                        if (bus.rsp_ready[gi]) begin
                            slot_q <= S_IDLE;
                        end
                    end
                    default: slot_q <= S_IDLE;
                endcase
            end
        end

        assign idle_vec[gi]            = (slot_q == S_IDLE);
        assign hold_vec[gi]            = (slot_q == S_HOLD);
        assign bus.rsp_valid[gi]       = rst_n & hold_vec[gi];
        assign bus.rsp_data[gi*N +: N] = data_q;
    end

    assign bus.busy = rst_n & ((|(~idle_vec)) | (|tag_vld));

endmodule

// File: tb/tb_posit_fma_arbiter.sv
// Directed bench for posit_fma_arbiter: single-op vector table plus multi-cycle
// round-robin, backpressure, sparse-set, mid-flight reset and passthrough sequences.
module tb_posit_fma_arbiter;
    localparam int N    = 32;
    localparam int NREQ = 4;
    localparam int LAT  = 3;
    localparam logic [31:0] NAR = 32'h8000_0000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;
    int   gcyc = 0;
    int   n_iss [NREQ];
    int   n_rsp [NREQ];
    int   iss_cyc [NREQ];
    logic prev_rv [NREQ];
    int   exp_g [20];

    typedef struct {
        int          id;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs [4];

    posit_fma_arbiter_if #(.N(N), .NREQ(NREQ)) bus ();

    posit_fma_arbiter #(.N(N), .ES(2), .NREQ(NREQ), .LAT(LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Stand-in datapath: exact for zero/NaR/2*1+1, an arbitrary fixed mix otherwise.
    function automatic logic [31:0] model_fma(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        if (a == NAR || b == NAR || c == NAR) return NAR;
        if (a == 32'h0 || b == 32'h0) return c;
        if (a == 32'h4800_0000 && b == 32'h4000_0000 && c == 32'h4000_0000) return 32'h4C00_0000;
        return a ^ {b[15:0], b[31:16]} ^ (c + 32'h1234_5678);
    endfunction

    logic [31:0] dp_q [LAT];
    always @(posedge clk) begin
        dp_q[0] <= bus.fma_valid ? model_fma(bus.fma_a, bus.fma_b, bus.fma_c) : 32'hDEAD_BEEF;
        for (int k = 1; k < LAT; k++) dp_q[k] <= dp_q[k-1];
    end
    assign bus.fma_out = dp_q[LAT-1];

    function automatic logic [31:0] op_a(input int i, input int k);
        return 32'h4000_0000 | (32'(i) << 20) | (32'(k) << 4);
    endfunction
    function automatic logic [31:0] op_b(input int i, input int k);
        return 32'h3800_0000 + 32'(k * 3 + i);
    endfunction
    function automatic logic [31:0] op_c(input int i, input int k);
        return 32'h1000_0000 | (32'(i) << 8) | 32'(k);
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        bus.req_valid = '0;
        bus.rsp_ready = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_c     = '0;
        @(negedge clk);
        rst_n = 1'b1;
        gcyc++;
        for (int i = 0; i < NREQ; i++) begin
            n_rsp[i]   = n_iss[i];
            prev_rv[i] = 1'b0;
        end
    endtask

    task automatic run_vec(input vec_t v);
        bus.req_valid = NREQ'(1) << v.id;
        bus.rsp_ready = '0;
        bus.req_a = '0; bus.req_b = '0; bus.req_c = '0;
        bus.req_a[v.id*N +: N] = v.a;
        bus.req_b[v.id*N +: N] = v.b;
        bus.req_c[v.id*N +: N] = v.c;
        #1;
        chk($sformatf("vec%0d req_ready", v.id), bus.req_ready, NREQ'(1) << v.id);
        chk($sformatf("vec%0d fma_valid", v.id), bus.fma_valid, 1);
        chk($sformatf("vec%0d fma_a", v.id), bus.fma_a, v.a);
        chk($sformatf("vec%0d fma_b", v.id), bus.fma_b, v.b);
        chk($sformatf("vec%0d fma_c", v.id), bus.fma_c, v.c);
        @(negedge clk);
        bus.req_valid = '0;
        for (int c = 1; c <= LAT; c++) begin
            #1;
            chk($sformatf("vec%0d c%0d rsp_valid early", v.id, c), bus.rsp_valid, 0);
            chk($sformatf("vec%0d c%0d busy", v.id, c), bus.busy, 1);
            @(negedge clk);
        end
        bus.rsp_ready = NREQ'(1) << v.id;
        #1;
        chk($sformatf("vec%0d rsp_valid", v.id), bus.rsp_valid, NREQ'(1) << v.id);
        chk($sformatf("vec%0d rsp_data", v.id), bus.rsp_data[v.id*N +: N], v.exp);
        @(negedge clk);
        bus.rsp_ready = '0;
        #1;
        chk($sformatf("vec%0d rsp_valid after hs", v.id), bus.rsp_valid, 0);
        chk($sformatf("vec%0d busy after hs", v.id), bus.busy, 0);
        chk($sformatf("vec%0d rsp_data kept", v.id), bus.rsp_data[v.id*N +: N], v.exp);
        @(negedge clk);
        gcyc += LAT + 3;
    endtask

    task automatic traffic(input logic [3:0] vmask, input int ncyc, input int r1_low_until,
                           input int rst_at, input string tag);
        int g;
        int nhot;
        for (int cyc = 0; cyc < ncyc; cyc++) begin
            rst_n         = (cyc != rst_at);
            bus.req_valid = vmask;
            for (int i = 0; i < NREQ; i++) begin
                bus.req_a[i*N +: N] = op_a(i, n_iss[i]);
                bus.req_b[i*N +: N] = op_b(i, n_iss[i]);
                bus.req_c[i*N +: N] = op_c(i, n_iss[i]);
            end
            bus.rsp_ready = 4'hF;
            if (cyc <= r1_low_until) bus.rsp_ready[1] = 1'b0;
            #1;
            g = -1;
            nhot = 0;
            for (int i = 0; i < NREQ; i++) begin
                if (bus.req_ready[i]) begin
                    g = i;
                    nhot++;
                end
            end
            chk($sformatf("%s c%0d grant", tag, cyc), g, exp_g[cyc]);
            chk($sformatf("%s c%0d multi grant", tag, cyc), nhot > 1, 0);
            chk($sformatf("%s c%0d ready w/o valid", tag, cyc), bus.req_ready & ~bus.req_valid, 0);
            chk($sformatf("%s c%0d fma_valid", tag, cyc), bus.fma_valid, g >= 0);
            if (g >= 0) begin
                chk($sformatf("%s c%0d fma_a", tag, cyc), bus.fma_a, op_a(g, n_iss[g]));
                chk($sformatf("%s c%0d fma_b", tag, cyc), bus.fma_b, op_b(g, n_iss[g]));
                chk($sformatf("%s c%0d fma_c", tag, cyc), bus.fma_c, op_c(g, n_iss[g]));
            end
            for (int i = 0; i < NREQ; i++) begin
                if (bus.rsp_valid[i]) begin
                    if (n_rsp[i] >= n_iss[i]) begin
                        chk($sformatf("%s c%0d spurious rsp_valid[%0d]", tag, cyc, i), 1, 0);
                    end else begin
                        chk($sformatf("%s c%0d rsp_data[%0d]", tag, cyc, i), bus.rsp_data[i*N +: N],
                            model_fma(op_a(i, n_rsp[i]), op_b(i, n_rsp[i]), op_c(i, n_rsp[i])));
                        if (!prev_rv[i]) begin
                            chk($sformatf("%s c%0d rsp latency[%0d]", tag, cyc, i), gcyc - iss_cyc[i], LAT + 1);
                        end
                        if (bus.rsp_ready[i]) n_rsp[i]++;
                    end
                end
                prev_rv[i] = bus.rsp_valid[i] & ~bus.rsp_ready[i];
            end
            if (!rst_n) begin
                chk($sformatf("%s c%0d rsp_valid in reset", tag, cyc), bus.rsp_valid, 0);
                chk($sformatf("%s c%0d busy in reset", tag, cyc), bus.busy, 0);
                for (int i = 0; i < NREQ; i++) begin
                    n_rsp[i]   = n_iss[i];
                    prev_rv[i] = 1'b0;
                end
            end else if (g >= 0) begin
                iss_cyc[g] = gcyc;
                n_iss[g]++;
            end
            if (rst_at >= 0 && cyc == rst_at + 1) begin
                chk($sformatf("%s c%0d busy after reset", tag, cyc), bus.busy, 0);
                chk($sformatf("%s c%0d rsp_valid after reset", tag, cyc), bus.rsp_valid, 0);
            end
            @(negedge clk);
            gcyc++;
        end
    endtask

    task automatic drain_and_check(input string tag);
        for (int k = 0; k < 20; k++) exp_g[k] = -1;
        traffic(4'h0, 10, -1, -1, {tag, " drain"});
        for (int i = 0; i < NREQ; i++) begin
            chk($sformatf("%s responses[%0d]", tag, i), n_rsp[i], n_iss[i]);
        end
        chk($sformatf("%s idle busy", tag), bus.busy, 0);
    endtask

    initial begin
        int pat_rr [20]     = '{0, 1, 2, 3, -1, 0, 1, 2, 3, -1, 0, 1, 2, 3, -1, 0, 1, 2, 3, -1};
        int pat_bp [20]     = '{0, 1, 2, 3, -1, 0, -1, 2, 3, -1, 0, -1, 2, 3, 1, 0, -1, 2, 3, 1};
        int pat_sparse [20] = '{1, 3, -1, -1, -1, 1, 3, -1, -1, -1, 1, 3, -1, -1, -1, 1, 3, -1, -1, -1};
        int pat_rst [20]    = '{0, 1, -1, 0, 1, 2, 3, -1, 0, 1, 2, 3, -1, 0, 1, 2, 3, -1, 0, 1};

        vecs[0] = '{id: 0, a: 32'h4800_0000, b: 32'h4000_0000, c: 32'h4000_0000, exp: 32'h4C00_0000};
        vecs[1] = '{id: 2, a: 32'h4000_0000, b: 32'h4000_0000, c: NAR,          exp: NAR};
        vecs[2] = '{id: 3, a: 32'h4800_0000, b: 32'h0000_0000, c: 32'h0000_0000, exp: 32'h0000_0000};
        vecs[3] = '{id: 1, a: 32'h0000_0000, b: 32'h4800_0000, c: 32'h4800_0000, exp: 32'h4800_0000};
        for (int i = 0; i < NREQ; i++) begin
            n_iss[i] = 0; n_rsp[i] = 0; iss_cyc[i] = 0; prev_rv[i] = 1'b0;
        end

        do_reset();
        for (int v = 0; v < 4; v++) run_vec(vecs[v]);

        // Responses are now held in rsp_data; reset must clear them.
        do_reset();
        #1;
        chk("reset rsp_valid", bus.rsp_valid, 0);
        chk("reset busy", bus.busy, 0);
        chk("reset fma_valid", bus.fma_valid, 0);
        chk("reset req_ready", bus.req_ready, 0);
        chk("reset rsp_data", bus.rsp_data, 0);
        @(negedge clk);
        gcyc++;

        exp_g = pat_rr;
        traffic(4'hF, 20, -1, -1, "rr");
        drain_and_check("rr");

        do_reset();
        exp_g = pat_bp;
        traffic(4'hF, 20, 12, -1, "bp");
        drain_and_check("bp");

        do_reset();
        exp_g = pat_sparse;
        traffic(4'hA, 20, -1, -1, "sparse");
        drain_and_check("sparse");

        do_reset();
        exp_g = pat_rst;
        traffic(4'hF, 20, -1, 2, "rst");
        drain_and_check("rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/posit_fma_arbiter.md
Name: posit_fma_arbiter

Overview:
Shares one fixed-latency, fully pipelined posit FMA datapath (decode → FMA → rounding/encode) among NREQ requesters. Each cycle it grants one requester round-robin and drives that requester's operands into the datapath. It tracks the requester ID through a tag pipeline matched to the datapath latency. It holds each result in a per-requester response register until the requester accepts it.

Parameters:
N, 32, posit word width
ES, 2, posit exponent size (passed through for documentation and checks only)
NREQ, 4, number of requesters (≥2)
LAT, 3, datapath latency in cycles from fma_valid to the matching fma_out (≥1)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  synchronous active-low reset
req_valid  input  NREQ  per-requester operation request
req_ready  output  NREQ  per-requester grant; handshake when req_valid[i]&req_ready[i]
req_a  input  NREQ*N  multiplicand operands, slice i = [i*N +: N]
req_b  input  NREQ*N  multiplier operands
req_c  input  NREQ*N  addend operands
fma_valid  output  1  issue strobe to datapath
fma_a, fma_b, fma_c  output  N each  operands to datapath
fma_out  input  N  datapath result; corresponds to the issue LAT cycles earlier
rsp_valid  output  NREQ  result held for requester i
rsp_ready  input  NREQ  requester i accepts result
rsp_data  output  NREQ*N  result registers, slice i
busy  output  1  any slot not IDLE or any tag in flight

Behaviour:
- Per-requester slot FSM with states IDLE, INFLIGHT and HOLD.
  - IDLE→INFLIGHT on the req handshake.
  - INFLIGHT→HOLD when the slot's tag exits the tag pipe.
  - HOLD→IDLE on rsp_valid&rsp_ready.
- Arbitration (combinational):
  - Eligible set: req_valid[i] & slot[i]==IDLE.
  - Scan from pointer ptr upward, wrapping mod NREQ; the first eligible index is granted.
  - At most one req_ready bit is high. req_ready[i] never asserts unless req_valid[i] is high.
- Issue:
  - fma_valid = |(req_valid&req_ready).
  - fma_a/b/c = granted slice, same cycle.
  - When there is no grant, fma_a/b/c are driven 0.
- Pointer: after a grant to index g, ptr ← (g+1) mod NREQ. Without a grant, ptr holds.
- Tag pipe:
  - LAT stages of {valid, id[$clog2(NREQ)-1:0]}. Stage 0 is loaded with {fma_valid, g} at the clock edge of the issue cycle.
  - The stage LAT-1 output marks the cycle in which fma_out is valid for that tag. That cycle is issue cycle t+LAT.
  - At the end of cycle t+LAT, rsp_data[id] ← fma_out and slot[id] → HOLD.
  - rsp_valid[id] = (slot==HOLD), which is high from cycle t+LAT+1.
- Results are passed unmodified. Zero (0x0) and NaR (0x80000000) from the datapath are stored like any other value.
- rsp_data[i] is stable while HOLD. It is not cleared on HOLD→IDLE.
- Per-requester issue rate:
  - The slot frees on the cycle after the response handshake, so the earliest re-issue is t+LAT+2 when rsp_ready is held high.
  - Aggregate throughput is up to 1 op/cycle when enough requesters are active.
- Simultaneous events:
  - A response handshake and a tag exit cannot target the same slot, because each slot allows only one op outstanding.
  - A tag exit and a new grant in the same cycle are independent.
- Reset (rst_n=0 at a rising edge):
  - Every slot goes to IDLE, ptr=0, all tag stages are invalid, rsp_data=0.
  - Outputs during reset: rsp_valid=0, req_ready=0, fma_valid=0, busy=0.
  - Operations in flight when reset asserts are discarded. fma_out arriving after reset is ignored because no valid tag exists.
- busy = (any slot != IDLE) | (any tag valid).

Test Plan:
1. Single op: reset, then req_valid[0]=1 at cycle 0 with a=0x48000000 (2.0), b=0x40000000 (1.0), c=0x40000000 (1.0); bench datapath model has LAT=3.
   → req_ready[0]=1 and fma_valid=1 at cycle 0; rsp_valid[0]=1 at cycle 4 with rsp_data[0]=0x4C000000 (3.0); busy returns to 0 after the handshake.
2. Four requesters valid continuously, rsp_ready=4'hF.
   → Grants are 0,1,2,3 at cycles 0–3; cycle 4 has no grant; grant 0 at cycle 5, 1 at 6, and so on.
   → rsp_valid[i] pulses exactly once per op, each with the correct slice.
3. Backpressure: scenario 2 with rsp_ready[1]=0 for cycles 0–12.
   → rsp_data[1] is stable from cycle 5 while rsp_valid[1]=1, and req_ready[1]=0 throughout.
   → Requesters 0, 2 and 3 keep round-robin issue. Requester 1 is re-granted one cycle after its handshake at cycle 13.
4. Fairness with a sparse set: only req_valid[1] and req_valid[3] high, rsp_ready=all 1s.
   → Grants alternate 1,3,1,3 (subject to slot availability). Requester 3 is never granted twice while 1 is eligible and waiting.
5. Reset mid-flight: rst_n=0 for one cycle at cycle 2 of scenario 2, while the bench model still emits fma_out.
   → All rsp_valid=0 and busy=0 from cycle 3, and no stale rsp_valid afterwards.
   → The next grant goes to the lowest-indexed valid requester (ptr=0).
6. NaR/zero passthrough: req2 c=0x80000000, bench model returns 0x80000000; req3 returns 0x00000000.
   → rsp_data[2]=0x80000000 and rsp_data[3]=0x00000000, each with rsp_valid asserted.
